// File: rtl/line_reader_if.sv
// Bundles the command, RAM-read and output-stream signals of line_reader.
// The reader itself uses the master modport; the RAM and the consumer sit on the slave side.
interface line_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH:0]   cmd_len;

    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    logic                  busy;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, mem_rd_data, out_ready,
        output cmd_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, mem_rd_data, out_ready,
        input  cmd_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/line_reader.sv
// Reads a burst of consecutive RAM words into a 2-deep buffer and streams them out; first word 3 cycles after the command.
// Backpressure: out_ready low stalls the head word and RAM reads stop once buffered plus in-flight words would exceed 2.
module line_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    line_reader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] dat;
    } entry_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;

    entry_t                fifo_q [2];
    entry_t                fifo_d [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            cnt_q, cnt_d;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_q          <= '{default: '0};
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            cnt_q           <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_q          <= fifo_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            cnt_q           <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        fifo_d          = fifo_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;

        pop      = (cnt_q != 2'd0) && bus.out_ready;
        push     = inflight_q;
        // Buffered + in-flight words after this edge must stay within the 2 buffer slots.
        occ_next = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue    = (state_q == RUN) && (rem_q != '0) && (occ_next < 3'd2);

        inflight_d      = issue;
        inflight_last_d = issue && (rem_q == (ADDR_WIDTH+1)'(1));

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d = bus.cmd_addr;
                    rem_d  = bus.cmd_len;
                    if (bus.cmd_len != '0) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - (ADDR_WIDTH+1)'(1);
                    if (rem_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((cnt_q == 2'd0) && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Returning RAM data is captured the cycle it appears, even while the head is popped.
        if (push) begin
            fifo_d[wr_ptr_q] = '{last: inflight_last_q, dat: bus.mem_rd_data};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.mem_rd_en   = issue;
    assign bus.mem_rd_addr = addr_q;
    assign bus.out_valid   = (cnt_q != 2'd0);
    assign bus.out_data    = fifo_q[rd_ptr_q].dat;
    assign bus.out_last    = fifo_q[rd_ptr_q].last;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/line_reader.md
LINE_READER -- requirements
Module: line_reader

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning): DATA_WIDTH, 32, word width; ADDR_WIDTH, 10, RAM address width.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning): clk, in, 1, sole clock.
REQ-003 rst_n, in, 1, asynchronous active-low reset.
REQ-004 cmd_valid, in, 1, read-burst request valid.
REQ-005 cmd_ready, out, 1, request accepted when high with cmd_valid.
REQ-006 cmd_addr, in, ADDR_WIDTH, first RAM word address.
REQ-007 cmd_len, in, ADDR_WIDTH+1, word count, range 0..2^ADDR_WIDTH.
REQ-008 mem_rd_en, out, 1, RAM read enable.
REQ-009 mem_rd_addr, out, ADDR_WIDTH, RAM read address.
REQ-010 mem_rd_data, in, DATA_WIDTH, RAM registered read data, valid in the cycle after mem_rd_en.
REQ-011 out_valid, out, 1, stream word valid.
REQ-012 out_ready, in, 1, downstream accept.
REQ-013 out_data, out, DATA_WIDTH, stream word.
REQ-014 out_last, out, 1, high with the final word of a burst.
REQ-015 busy, out, 1, high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DRAIN; cmd_ready SHALL be high only in IDLE.
REQ-017 IDLE: on cmd_valid&&cmd_ready, latch addr=cmd_addr and remaining=cmd_len; go to RUN if cmd_len>0, otherwise stay in IDLE (zero-length command consumed, no output).
REQ-018 Output buffer: a 2-entry FIFO holds returned words; inflight=1 in the cycle following a mem_rd_en pulse; pop=out_valid&&out_ready.
REQ-019 RUN: mem_rd_en SHALL assert when remaining>0 and (occupancy+inflight-pop)<2; each issue drives mem_rd_addr=addr, then addr+1 mod 2^ADDR_WIDTH and remaining-1.
REQ-020 Address wrap: addr 2^ADDR_WIDTH-1 SHALL be followed by 0 without error.
REQ-021 With out_ready held high, throughput SHALL be one word per cycle after the first word.
REQ-022 Latency: cmd handshake in cycle T; first mem_rd_en in T+1; first out_valid in T+3.
REQ-023 mem_rd_data SHALL be written into the FIFO in the cycle it is valid (inflight=1), including simultaneously with a pop.
REQ-024 The FIFO SHALL never overflow or underflow; out_valid = occupancy>0; out_data/out_last = head entry, held stable while out_valid&&!out_ready.
REQ-025 out_last SHALL be tagged on the word issued when remaining was 1.
REQ-026 RUN goes to DRAIN when remaining reaches 0; DRAIN goes to IDLE in the cycle after occupancy==0 and inflight==0.
REQ-027 cmd_len=2^ADDR_WIDTH SHALL read every address exactly once, starting at cmd_addr.

Reset
REQ-028 On rst_n low (any time, including mid-burst): state=IDLE; cmd_ready=1 after release; mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0; FIFO emptied; inflight, addr and remaining cleared; returning RAM data is discarded.

Verification
REQ-029 cmd_addr=0x010, cmd_len=4, out_ready=1 -> words from 0x010..0x013 on consecutive cycles T+3..T+6, out_last only on the 4th; busy low by T+8.
REQ-030 cmd_addr=0x3FE, cmd_len=4 -> mem_rd_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
REQ-031 cmd_len=8, out_ready toggling 1,0,0,1 repeated -> exactly 8 words in order, no duplicates or drops, data stable while stalled, mem_rd_en pauses when the FIFO is full.
REQ-032 cmd_len=0 -> cmd accepted, no mem_rd_en, no out_valid, cmd_ready stays 1.
REQ-033 rst_n pulsed low after 3 words of a 16-word burst -> all outputs at reset values; a new cmd_len=2 burst completes correctly.
REQ-034 cmd_len=1024 with ADDR_WIDTH=10, random out_ready -> 1024 words, each address exactly once, out_last on the final word.
